// File: rtl/cart_mbc1.sv
// MBC1 cartridge mapper: bank registers, ROM/RAM address translation and a memory-side request FSM.
// Cart RAM support is compiled in only when CART_MBC1_RAM_EN is defined.
module cart_mbc1 #(
  parameter int unsigned ROM_BANK_BITS = 7,
  parameter int unsigned RAM_BANK_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               a,
  input  logic [7:0]                din,
  input  logic                      wr,
  input  logic                      rd,
  input  logic                      cs,
  output logic [7:0]                dout,
  output logic [14+ROM_BANK_BITS-1:0] mem_addr,
  output logic                      mem_ram,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ack,
  output logic                      busy
);

  localparam int unsigned ADDR_W = 14 + ROM_BANK_BITS;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e              state_q, state_d;
  logic                rd_q, wr_q;
  logic [4:0]          bank5_q, bank5_d;
  logic [1:0]          bank2_q, bank2_d;
  logic                mode_q, mode_d;
  logic [7:0]          dout_q, dout_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_ram_q, mem_ram_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;

  logic                rd_edge, wr_edge, is_rom, is_ram, ram_ok;
  logic [6:0]          rom_bank_full;
  logic [ADDR_W-1:0]   rom_addr, ram_addr;

  assign rd_edge = rd & ~rd_q;
  assign wr_edge = wr & ~wr_q;
  assign is_rom  = ~a[15];
  assign is_ram  = (a[15:13] == 3'b101);

  // Lower ROM window is bank 0 unless mode 1 lets bank2 reach into it
  assign rom_bank_full = a[14] ? {bank2_q, bank5_q} : (mode_q ? {bank2_q, 5'b0} : 7'd0);
  assign rom_addr      = {ROM_BANK_BITS'(rom_bank_full), a[13:0]};

`ifdef CART_MBC1_RAM_EN
  logic                     ram_en_q, ram_en_d;
  logic [RAM_BANK_BITS-1:0] ram_bank;

  assign ram_bank = RAM_BANK_BITS'(mode_q ? bank2_q : 2'd0);
  assign ram_addr = ADDR_W'({ram_bank, a[12:0]});
  assign ram_ok   = cs & ram_en_q;

  always_ff @(posedge clk) begin
    if (rst) ram_en_q <= 1'b0;
    else     ram_en_q <= ram_en_d;
  end
`else
  logic unused_cs;

  assign unused_cs = cs;
  assign ram_addr  = '0;
  assign ram_ok    = 1'b0;
`endif

  // Bank register writes land regardless of FSM state
  always_comb begin
    bank5_d = bank5_q;
    bank2_d = bank2_q;
    mode_d  = mode_q;
`ifdef CART_MBC1_RAM_EN
    ram_en_d = ram_en_q;
`endif
    if (wr_edge && !a[15]) begin
      if (a[14:13] == 2'd0) begin
`ifdef CART_MBC1_RAM_EN
        ram_en_d = (din[3:0] == 4'hA);
`endif
      end else if (a[14:13] == 2'd1) begin
        bank5_d = (din[4:0] == 5'd0) ? 5'd1 : din[4:0];
      end else if (a[14:13] == 2'd2) begin
        bank2_d = din[1:0];
      end else begin
        mode_d = din[0];
      end
    end
  end

  // Request FSM: next state and registered bus outputs
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    mem_addr_d  = mem_addr_q;
    mem_ram_d   = mem_ram_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (rd_edge) begin
          if (is_rom) begin
            state_d    = READ;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_ram_d  = 1'b0;
            mem_addr_d = rom_addr;
          end else if (is_ram) begin
            if (ram_ok) begin
              state_d    = READ;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_ram_d  = 1'b1;
              mem_addr_d = ram_addr;
            end else begin
              dout_d = 8'hFF;
            end
          end
        end else if (wr_edge && is_ram && ram_ok) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_ram_d   = 1'b1;
          mem_addr_d  = ram_addr;
          mem_wdata_d = din;
        end
      end
      READ: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dout_d    = mem_rdata;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bank5_q     <= 5'd1;
      bank2_q     <= 2'd0;
      mode_q      <= 1'b0;
      dout_q      <= 8'hFF;
      mem_addr_q  <= '0;
      mem_ram_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd;
      wr_q        <= wr;
      bank5_q     <= bank5_d;
      bank2_q     <= bank2_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_ram_q   <= mem_ram_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign dout      = dout_q;
  assign mem_addr  = mem_addr_q;
  assign mem_ram   = mem_ram_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cart_mbc1.sv
// Directed bench for cart_mbc1: bank mapping, RAM gating, request handshake, drops and reset abort.
module tb_cart_mbc1;

  logic        clk = 1'b0;
  logic        rst, wr, rd, cs, mem_ram, mem_req, mem_we, mem_ack, busy;
  logic [15:0] a;
  logic [7:0]  din, dout, mem_wdata, mem_rdata;
  logic [20:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cart_mbc1 dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .wr(wr), .rd(rd), .cs(cs),
    .dout(dout), .mem_addr(mem_addr), .mem_ram(mem_ram), .mem_req(mem_req),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [15:0] addr, input logic [7:0] d);
    a = addr; din = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
  endtask

  // Full read transaction with single-cycle ack
  task automatic do_read(input string tag, input logic [15:0] addr, input logic c,
                         input logic [20:0] exp_addr, input logic exp_ram, input logic [7:0] rdata);
    a = addr; cs = c; rd = 1'b1;
    tick();
    chk({tag, " req"},  32'(mem_req), 32'd1);
    chk({tag, " addr"}, 32'(mem_addr), 32'(exp_addr));
    chk({tag, " ram"},  32'(mem_ram), 32'(exp_ram));
    chk({tag, " we"},   32'(mem_we), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    rd = 1'b0; mem_rdata = rdata; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, " dout"},     32'(dout), 32'(rdata));
    chk({tag, " idle"},     32'(busy), 32'd0);
    chk({tag, " req_low"},  32'(mem_req), 32'd0);
  endtask

  // Read edge that must not produce a request
  task automatic no_req_read(input string tag, input logic [15:0] addr, input logic c,
                             input logic [7:0] exp_dout);
    a = addr; cs = c; rd = 1'b1;
    tick();
    chk({tag, " dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, " noreq"}, 32'(mem_req), 32'd0);
    chk({tag, " nobusy"}, 32'(busy), 32'd0);
    rd = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; a = 16'h0; din = 8'h0; wr = 1'b0; rd = 1'b0; cs = 1'b0;
    mem_rdata = 8'h0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst dout",  32'(dout), 32'hFF);
    chk("rst req",   32'(mem_req), 32'd0);
    chk("rst we",    32'(mem_we), 32'd0);
    chk("rst busy",  32'(busy), 32'd0);
    chk("rst addr",  32'(mem_addr), 32'd0);
    chk("rst wdata", 32'(mem_wdata), 32'd0);
    chk("rst ram",   32'(mem_ram), 32'd0);
    rst = 1'b0;
    tick();

    // Power-on bank 1 in the switchable window
    do_read("rd4000", 16'h4000, 1'b0, 21'h04000, 1'b0, 8'h3C);

    // Bank 0 write maps to bank 1, then bank 0x13
    reg_wr(16'h2000, 8'h00);
    do_read("bank0", 16'h4000, 1'b0, 21'h04000, 1'b0, 8'h01);
    reg_wr(16'h2000, 8'h13);
    do_read("bank13", 16'h4ABC, 1'b0, 21'h4CABC, 1'b0, 8'h02);

    // Upper bits and mode 1 in the lower window
    reg_wr(16'h4000, 8'h02);
    reg_wr(16'h6000, 8'h01);
    do_read("mode1", 16'h0123, 1'b0, 21'h100123, 1'b0, 8'h03);
    do_read("bank53", 16'h4ABC, 1'b0, 21'h14CABC, 1'b0, 8'h04);
    reg_wr(16'h6000, 8'h00);
    do_read("mode0", 16'h0123, 1'b0, 21'h000123, 1'b0, 8'h05);

    // RAM disabled: reads float high, no request
    no_req_read("ramoff", 16'hA000, 1'b1, 8'hFF);
    reg_wr(16'h0000, 8'h0A);
    a = 16'hA010; din = 8'h55; cs = 1'b1; wr = 1'b1;
    tick();
`ifdef CART_MBC1_RAM_EN
    chk("ramwr req",   32'(mem_req), 32'd1);
    chk("ramwr we",    32'(mem_we), 32'd1);
    chk("ramwr ram",   32'(mem_ram), 32'd1);
    chk("ramwr wdata", 32'(mem_wdata), 32'h55);
    chk("ramwr addr",  32'(mem_addr), 32'h0010);
    wr = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ramwr done", 32'(mem_req), 32'd0);
    chk("ramwr idle", 32'(busy), 32'd0);
    do_read("ramrd", 16'hA123, 1'b1, 21'h00123, 1'b1, 8'h77);
    reg_wr(16'h6000, 8'h01);
    do_read("ramrd_m1", 16'hA010, 1'b1, 21'h04010, 1'b1, 8'h78);
    reg_wr(16'h6000, 8'h00);
`else
    chk("ramwr noreq", 32'(mem_req), 32'd0);
    chk("ramwr nobusy", 32'(busy), 32'd0);
    chk("ramwr ram0", 32'(mem_ram), 32'd0);
    wr = 1'b0;
    tick();
    no_req_read("ramrd_off", 16'hA123, 1'b1, 8'hFF);
`endif

    // cs low and RAM re-disabled both return 0xFF
    do_read("pre_cs", 16'h0010, 1'b0, 21'h00010, 1'b0, 8'h42);
    no_req_read("cs0", 16'hA000, 1'b0, 8'hFF);
    do_read("pre_dis", 16'h0011, 1'b0, 21'h00011, 1'b0, 8'h43);
    reg_wr(16'h0000, 8'h00);
    no_req_read("ramdis", 16'hA000, 1'b1, 8'hFF);

    // Unmapped regions are ignored
    do_read("pre_gap", 16'h0012, 1'b0, 21'h00012, 1'b0, 8'h5A);
    no_req_read("gapC000", 16'hC000, 1'b1, 8'h5A);
    no_req_read("gap8000", 16'h8000, 1'b1, 8'h5A);

    // Long wait: stable request, dropped edge, bank write does not move latched address
    a = 16'h7FFF; rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 16'h4000; rd = 1'b1; end
      if (i == 4) rd = 1'b0;
      if (i == 6) begin a = 16'h2000; din = 8'h05; wr = 1'b1; end
      if (i == 7) wr = 1'b0;
      chk("wait req",  32'(mem_req), 32'd1);
      chk("wait addr", 32'(mem_addr), 32'h14FFFF);
      chk("wait busy", 32'(busy), 32'd1);
      tick();
    end
    mem_rdata = 8'h99; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wait dout", 32'(dout), 32'h99);
    chk("wait idle", 32'(busy), 32'd0);
    tick();
    chk("dropped edge", 32'(mem_req), 32'd0);
    do_read("bank45", 16'h4000, 1'b0, 21'h114000, 1'b0, 8'h11);

    // Reset mid-request aborts; stray ack afterwards ignored
    a = 16'h4000; rd = 1'b1;
    tick();
    chk("abort started", 32'(mem_req), 32'd1);
    rd = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort req",  32'(mem_req), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort dout", 32'(dout), 32'hFF);
    rst = 1'b0; mem_rdata = 8'hAB; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray req",  32'(mem_req), 32'd0);
    chk("stray busy", 32'(busy), 32'd0);
    chk("stray dout", 32'(dout), 32'hFF);
    do_read("post_rst", 16'h4000, 1'b0, 21'h04000, 1'b0, 8'h21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
